// File: rtl/clk_div_sched.sv
// Programmable multi-channel clock divider with a valid/ready config port.
// Reconfiguring a running channel is deferred to its falling boundary so no runt pulses appear.

module clk_div_lane #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_hp,
  input  logic             i_load_en,
  output logic             o_clk,
  output logic             o_tick,
  output logic             o_en,
  output logic             o_fall
);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_hp, r_cnt;
  logic             r_en, r_clk, r_tick;
  logic             w_wrap;

  assign w_wrap = (r_cnt == r_hp - ONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_en   <= 1'b0;
      r_hp   <= ONE;
      r_cnt  <= '0;
      r_clk  <= 1'b0;
      r_tick <= 1'b0;
    end else if (i_load) begin
      // a load also acts as the normal fall when it lands on the boundary
      r_en   <= i_load_en;
      r_hp   <= i_load_hp;
      r_cnt  <= '0;
      r_clk  <= 1'b0;
      r_tick <= 1'b0;
    end else if (r_en) begin
      if (w_wrap) begin
        r_cnt  <= '0;
        r_clk  <= ~r_clk;
        r_tick <= ~r_clk;
      end else begin
        r_cnt  <= r_cnt + ONE;
        r_tick <= 1'b0;
      end
    end else begin
      r_cnt  <= '0;
      r_clk  <= 1'b0;
      r_tick <= 1'b0;
    end
  end

  assign o_clk  = r_clk;
  assign o_tick = r_tick;
  assign o_en   = r_en;
  assign o_fall = r_en && r_clk && w_wrap;
endmodule

module clk_div_sched #(
  parameter int NUM_CH = 3,
  parameter int CNT_W  = 8,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_half_period,
  input  logic              cfg_en,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] div_clk,
  output logic [NUM_CH-1:0] div_tick,
  output logic              busy
);
  localparam logic [1:0]       S_IDLE  = 2'd0;
  localparam logic [1:0]       S_APPLY = 2'd1;
  localparam logic [1:0]       S_WAIT  = 2'd2;
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CH_W:0]    LP_NCH  = (CH_W+1)'(NUM_CH);
  localparam int               PAD_N   = 1 << CH_W;

  logic [1:0]       r_state;
  logic [CH_W-1:0]  r_pch;
  logic [CNT_W-1:0] r_php;
  logic             r_pen;
  logic             r_err;

  logic [NUM_CH-1:0] w_en, w_fall, w_load;
  logic [PAD_N-1:0]  w_en_pad, w_fall_pad;
  logic              w_accept, w_bad, w_pend_fall;
  logic [CNT_W-1:0]  w_hp_in;

  assign cfg_ready = (r_state == S_IDLE) && !rst;
  assign busy      = (r_state != S_IDLE);
  assign cfg_err   = r_err;
  assign w_accept  = cfg_valid && cfg_ready;
  assign w_bad     = ({1'b0, cfg_ch} >= LP_NCH);
  assign w_hp_in   = (cfg_half_period == '0) ? ONE : cfg_half_period;

  // pad per-channel vectors to the full select range so any cfg_ch indexes safely
  always_comb begin
    w_en_pad                = '0;
    w_fall_pad              = '0;
    w_en_pad[NUM_CH-1:0]    = w_en;
    w_fall_pad[NUM_CH-1:0]  = w_fall;
  end
  assign w_pend_fall = w_fall_pad[r_pch];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pch   <= '0;
      r_php   <= ONE;
      r_pen   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_accept && w_bad;
      case (r_state)
        S_IDLE: if (w_accept && !w_bad) begin
          r_pch   <= cfg_ch;
          r_php   <= w_hp_in;
          r_pen   <= cfg_en;
          r_state <= w_en_pad[cfg_ch] ? S_WAIT : S_APPLY;
        end
        S_APPLY: r_state <= S_IDLE;
        S_WAIT:  if (w_pend_fall) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    assign w_load[i] = (r_pch == CH_W'(i)) &&
                       ((r_state == S_APPLY) || ((r_state == S_WAIT) && w_fall[i]));
    clk_div_lane #(.CNT_W(CNT_W)) u_lane (
      .clk       (clk),
      .rst       (rst),
      .i_load    (w_load[i]),
      .i_load_hp (r_php),
      .i_load_en (r_pen),
      .o_clk     (div_clk[i]),
      .o_tick    (div_tick[i]),
      .o_en      (w_en[i]),
      .o_fall    (w_fall[i])
    );
  end
endmodule

// File: tb/tb_clk_div_sched.sv
// Directed bench for clk_div_sched: hand-computed per-cycle expectations, sampled 1ns after each edge.

module tb_clk_div_sched;
  logic       clk, rst, cfg_valid, cfg_ready, cfg_en, cfg_err, busy;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_half_period;
  logic [2:0] div_clk, div_tick;
  int checks = 0;
  int errors = 0;

  clk_div_sched #(.NUM_CH(3), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_half_period(cfg_half_period), .cfg_en(cfg_en),
    .cfg_err(cfg_err), .div_clk(div_clk), .div_tick(div_tick), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [1:0] ch, input logic [7:0] hp, input logic en);
    cfg_valid = 1'b1; cfg_ch = ch; cfg_half_period = hp; cfg_en = en;
    step(1);
    cfg_valid = 1'b0;
  endtask

  initial begin
    logic [2:0] e_clk [7];
    logic [2:0] e_tck [7];
    logic [7:0] v_clk, v_tck;
    logic [5:0] w_clk, w_tck;

    rst = 1'b1; cfg_valid = 1'b0; cfg_ch = '0; cfg_half_period = '0; cfg_en = 1'b0;
    step(2);
    chk("rst_clk",   div_clk,   3'b000);
    chk("rst_tick",  div_tick,  3'b000);
    chk("rst_err",   cfg_err,   1'b0);
    chk("rst_busy",  busy,      1'b0);
    chk("rst_ready", cfg_ready, 1'b0);
    rst = 1'b0; #1;
    chk("post_rst_ready", cfg_ready, 1'b1);

    // ch0 hp=1, ch1 hp=2
    send(2'd0, 8'd1, 1'b1);
    chk("apply_busy",  busy,      1'b1);
    chk("apply_ready", cfg_ready, 1'b0);
    step();
    chk("ch0_loaded", div_clk, 3'b000);
    chk("idle_busy",  busy,    1'b0);
    send(2'd1, 8'd2, 1'b1);
    chk("ch0_rise_clk",  div_clk,  3'b001);
    chk("ch0_rise_tick", div_tick, 3'b001);
    e_clk = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b000, 3'b001, 3'b010};
    e_tck = '{3'b000, 3'b001, 3'b010, 3'b001, 3'b000, 3'b001, 3'b010};
    for (int k = 0; k < 7; k++) begin
      step();
      chk($sformatf("run_clk%0d", k),  div_clk,  e_clk[k]);
      chk($sformatf("run_tick%0d", k), div_tick, e_tck[k]);
    end

    // ch1 high with cnt=0: change to hp=4, old high phase must finish
    send(2'd1, 8'd4, 1'b1);
    chk("wait_busy",  busy,       1'b1);
    chk("wait_ready", cfg_ready,  1'b0);
    chk("wait_ch1hi", div_clk[1], 1'b1);
    step();
    chk("wait_fall_ch1",  div_clk[1], 1'b0);
    chk("wait_done_busy", busy,       1'b0);
    v_clk = 8'b0111_1000;
    v_tck = 8'b0000_1000;
    for (int k = 0; k < 8; k++) begin
      step();
      chk($sformatf("hp4_clk%0d", k),  div_clk[1],  v_clk[k]);
      chk($sformatf("hp4_tick%0d", k), div_tick[1], v_tck[k]);
      chk($sformatf("ch0_free%0d", k), div_clk[0],  (k % 2 == 0));
    end

    // disable ch0 running at hp=3 mid high phase
    rst = 1'b1; step(); rst = 1'b0;
    send(2'd0, 8'd3, 1'b1);
    step(4);
    chk("hp3_rise", div_clk[0],  1'b1);
    chk("hp3_tick", div_tick[0], 1'b1);
    send(2'd0, 8'd3, 1'b0);
    chk("dis_hold1", div_clk[0], 1'b1);
    chk("dis_busy1", busy,       1'b1);
    step();
    chk("dis_hold2", div_clk[0], 1'b1);
    step();
    chk("dis_fall",  div_clk[0], 1'b0);
    chk("dis_busy3", busy,       1'b0);
    for (int k = 0; k < 10; k++) begin
      step();
      chk($sformatf("dis_clk%0d", k),  div_clk,  3'b000);
      chk($sformatf("dis_tick%0d", k), div_tick, 3'b000);
    end

    // nonexistent channel, then hp=0 on ch2
    send(2'd3, 8'd5, 1'b1);
    chk("err_pulse", cfg_err,   1'b1);
    chk("err_clk",   div_clk,   3'b000);
    chk("err_ready", cfg_ready, 1'b1);
    chk("err_busy",  busy,      1'b0);
    step();
    chk("err_clear", cfg_err, 1'b0);
    send(2'd2, 8'd0, 1'b1);
    chk("hp0_noerr", cfg_err, 1'b0);
    chk("hp0_busy",  busy,    1'b1);
    step();
    chk("hp0_load", div_clk, 3'b000);
    step();
    chk("hp0_rise", div_clk,  3'b100);
    chk("hp0_tick", div_tick, 3'b100);
    step();
    chk("hp0_fall", div_clk,  3'b000);
    step();
    chk("hp0_rise2", div_clk, 3'b100);

    // accept lands on ch1's falling boundary: that one is ignored
    rst = 1'b1; step(); rst = 1'b0;
    send(2'd1, 8'd2, 1'b1);
    step(4);
    chk("bnd_hi", div_clk[1], 1'b1);
    send(2'd1, 8'd3, 1'b1);
    chk("bnd_fall_old", div_clk[1], 1'b0);
    chk("bnd_busy0",    busy,       1'b1);
    step();
    chk("bnd_low",   div_clk[1], 1'b0);
    chk("bnd_busy1", busy,       1'b1);
    step();
    chk("bnd_rise",  div_clk[1],  1'b1);
    chk("bnd_tick",  div_tick[1], 1'b1);
    step();
    chk("bnd_hi2",   div_clk[1], 1'b1);
    chk("bnd_busy3", busy,       1'b1);
    step();
    chk("bnd_apply", div_clk[1], 1'b0);
    chk("bnd_idle",  busy,       1'b0);
    w_clk = 6'b011100;
    w_tck = 6'b000100;
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("hp3_clk%0d", k),  div_clk[1],  w_clk[k]);
      chk($sformatf("hp3_tick%0d", k), div_tick[1], w_tck[k]);
    end

    // reset while waiting for a boundary
    send(2'd1, 8'd1, 1'b1);
    chk("rw_busy", busy, 1'b1);
    rst = 1'b1; #1;
    chk("rw_ready_rst", cfg_ready, 1'b0);
    step();
    chk("rw_clk",   div_clk,   3'b000);
    chk("rw_tick",  div_tick,  3'b000);
    chk("rw_busy0", busy,      1'b0);
    chk("rw_ready", cfg_ready, 1'b0);
    rst = 1'b0; #1;
    chk("rw_ready_after", cfg_ready, 1'b1);
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("rw_idle%0d", k), div_clk, 3'b000);
      chk($sformatf("rw_nb%0d", k),   busy,    1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
